// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between the instruction-fetch
//               port (IF) and the load/store port (LS). Each access walks
//               IDLE -> REQ -> WAIT and finishes with a one-cycle ack on the
//               owning port. LS normally wins a tie, but after STARVE_MAX
//               back-to-back LS grants with IF waiting, IF is forced through.
//               A WAIT phase longer than TIMEOUT cycles aborts the access
//               with an o_err pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   if_req/if_addr        fetch request and address
//   if_rdata/if_ack       fetch data and one-cycle completion pulse
//   ls_req/ls_we/ls_bmask LSU request, store flag, store byte enables
//   ls_addr/ls_wdata      LSU address and store data
//   ls_rdata/ls_ack       load data and one-cycle completion pulse
//   mem_req               one-cycle issue strobe to memory
//   mem_we/mem_bmask      write enable and byte enables (held until next grant)
//   mem_addr/mem_wdata    address and write data (held until next grant)
//   mem_rvalid/mem_rdata  memory response (also marks write completion)
//   o_stall_if/o_stall_ls combinational hold requests to the hazard logic
//   o_err                 one-cycle pulse when an access times out
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // load/store port
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [3:0]        ls_bmask,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ack,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_bmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  // hazard / status
  output logic              o_stall_if,
  output logic              o_stall_ls,
  output logic              o_err
);

  localparam logic [3:0] c_STARVE_MAX   = 4'(STARVE_MAX);
  // The timer holds (WAIT cycles elapsed - 1); reaching this value means the
  // current cycle is the TIMEOUT-th WAIT cycle without a response.
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner;       // 1 = LS owns the access, 0 = IF
  logic [3:0]          r_starve_cnt;
  logic [7:0]          r_timer;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [3:0]          r_mem_bmask;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                r_if_ack;
  logic                r_ls_ack;
  logic                r_err;

  logic                w_idle;
  logic                w_grant_ls;
  logic                w_grant_if;
  logic                w_owner_req;
  logic                w_timeout;

  assign w_idle      = (r_state == ST_IDLE);
  // LS wins ties until it has starved IF for STARVE_MAX grants in a row.
  assign w_grant_ls  = w_idle && ls_req && (r_starve_cnt < c_STARVE_MAX);
  assign w_grant_if  = w_idle && !w_grant_ls && if_req;
  // A requester that withdrew (fetch flush) gets no ack for its response.
  assign w_owner_req = r_owner ? ls_req : if_req;
  assign w_timeout   = (r_timer == c_TIMEOUT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_timer      <= 8'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_bmask  <= 4'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_ls_ack     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // single-cycle pulses
      r_mem_req <= 1'b0;
      r_if_ack  <= 1'b0;
      r_ls_ack  <= 1'b0;
      r_err     <= 1'b0;

      // Starvation tracking: only LS grants that overtake a waiting fetch
      // count; the grant condition already bounds the count at STARVE_MAX.
      if (w_grant_if || !if_req) begin
        r_starve_cnt <= 4'd0;
      end else if (w_grant_ls) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_grant_ls) begin
            r_owner     <= 1'b1;
            r_mem_addr  <= ls_addr;
            r_mem_we    <= ls_we;
            r_mem_bmask <= ls_bmask;
            r_mem_wdata <= ls_wdata;
            r_mem_req   <= 1'b1;
            r_state     <= ST_REQ;
          end else if (w_grant_if) begin
            r_owner     <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_we    <= 1'b0;
            r_mem_bmask <= 4'hF;
            r_mem_wdata <= '0;
            r_mem_req   <= 1'b1;
            r_state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          r_timer <= 8'd0;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          // A response in the timeout cycle still counts as a completion.
          if (mem_rvalid) begin
            if (w_owner_req) begin
              if (r_owner) begin
                r_ls_rdata <= mem_rdata;
                r_ls_ack   <= 1'b1;
              end else begin
                r_if_rdata <= mem_rdata;
                r_if_ack   <= 1'b1;
              end
            end
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            if (r_owner) begin
              r_ls_rdata <= '0;
              r_ls_ack   <= 1'b1;
            end else begin
              r_if_rdata <= '0;
              r_if_ack   <= 1'b1;
            end
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_bmask  = r_mem_bmask;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign if_rdata   = r_if_rdata;
  assign ls_rdata   = r_ls_rdata;
  assign if_ack     = r_if_ack;
  assign ls_ack     = r_ls_ack;
  assign o_err      = r_err;

  assign o_stall_if = if_req & ~r_if_ack;
  assign o_stall_ls = ls_req & ~r_ls_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Inputs are
//               driven 1 ns after each rising edge, outputs are checked 1 ns
//               later, so every check sees the state of the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_bmask;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        o_stall_if;
  logic        o_stall_ls;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_bmask(ls_bmask), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_bmask(mem_bmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .o_stall_if(o_stall_if), .o_stall_ls(o_stall_ls), .o_err(o_err)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    if_req     = 1'b0;
    if_addr    = 32'h0;
    ls_req     = 1'b0;
    ls_we      = 1'b0;
    ls_bmask   = 4'h0;
    ls_addr    = 32'h0;
    ls_wdata   = 32'h0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_if_ack", if_ack, 0);
    chk("rst_ls_ack", ls_ack, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_bmask", mem_bmask, 0);
    chk("rst_err", o_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    i_rst_n = 1'b1;
    tick();

    // ---------------- 1: IF read, back-to-back ----------------
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("t1_stall_T", o_stall_if, 1);
    chk("t1_noreq_T", mem_req, 0);
    tick();                                   // T+1: REQ
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_bmask", mem_bmask, 4'hF);
    chk("t1_stall_T1", o_stall_if, 1);
    tick();                                   // T+2: WAIT, response
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_req_pulse", mem_req, 0);
    chk("t1_noack_T2", if_ack, 0);
    chk("t1_stall_T2", o_stall_if, 1);
    tick();                                   // T+3: ack, next fetch presented
    mem_rvalid = 1'b0; if_addr = 32'h104;
    #1;
    chk("t1_ack", if_ack, 1);
    chk("t1_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_stall_ack", o_stall_if, 0);
    tick();                                   // REQ for 0x104
    chk("t1_ack_pulse", if_ack, 0);
    chk("t1b_mem_req", mem_req, 1);
    chk("t1b_mem_addr", mem_addr, 32'h104);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_rvalid = 1'b0; if_req = 1'b0;
    #1;
    chk("t1b_ack", if_ack, 1);
    chk("t1b_rdata", if_rdata, 32'h0BADF00D);
    chk("t1b_stall", o_stall_if, 0);
    tick();
    chk("t1_idle_req", mem_req, 0);

    // ---------------- 2: simultaneous IF + LS load ----------------
    if_req = 1'b1; if_addr = 32'h200;
    ls_req = 1'b1; ls_we = 1'b0; ls_bmask = 4'hF; ls_addr = 32'h2000;
    #1;
    chk("t2_stall_ls", o_stall_ls, 1);
    tick();
    chk("t2_ls_first_req", mem_req, 1);
    chk("t2_ls_first_addr", mem_addr, 32'h2000);
    chk("t2_ls_we", mem_we, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_rvalid = 1'b0; ls_req = 1'b0;
    #1;
    chk("t2_ls_ack", ls_ack, 1);
    chk("t2_ls_rdata", ls_rdata, 32'hCAFE0001);
    chk("t2_if_noack", if_ack, 0);
    chk("t2_if_stall", o_stall_if, 1);
    tick();
    chk("t2_if_req", mem_req, 1);
    chk("t2_if_addr", mem_addr, 32'h200);
    chk("t2_if_bmask", mem_bmask, 4'hF);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_rvalid = 1'b0; if_req = 1'b0;
    #1;
    chk("t2_if_ack", if_ack, 1);
    chk("t2_if_rdata", if_rdata, 32'h11112222);
    tick();

    // ---------------- 3: starvation, four LS then IF ----------------
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b1; ls_bmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ls_addr  = 32'h4000 + 32'(i * 4);
      ls_wdata = 32'hA000_0000 + 32'(i);
      tick();
      chk("t3_ls_req", mem_req, 1);
      chk("t3_ls_addr", mem_addr, 32'h4000 + 32'(i * 4));
      chk("t3_ls_we", mem_we, 1);
      tick();
      mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("t3_ls_ack", ls_ack, 1);
      chk("t3_if_wait", if_ack, 0);
    end
    ls_addr = 32'h4010;
    tick();
    chk("t3_if_forced_req", mem_req, 1);
    chk("t3_if_forced_addr", mem_addr, 32'h300);
    chk("t3_if_forced_we", mem_we, 0);
    chk("t3_ls_stalled", o_stall_ls, 1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h33334444;
    tick();
    mem_rvalid = 1'b0; if_req = 1'b0;
    #1;
    chk("t3_if_ack", if_ack, 1);
    chk("t3_if_rdata", if_rdata, 32'h33334444);
    tick();
    chk("t3_ls_resume_req", mem_req, 1);
    chk("t3_ls_resume_addr", mem_addr, 32'h4010);
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0; ls_req = 1'b0;
    #1;
    chk("t3_ls_resume_ack", ls_ack, 1);
    tick();

    // ---------------- 4: store with partial byte mask ----------------
    ls_req = 1'b1; ls_we = 1'b1; ls_bmask = 4'b0011;
    ls_wdata = 32'h1234_5678; ls_addr = 32'h7000;
    tick();
    chk("t4_req", mem_req, 1);
    chk("t4_we", mem_we, 1);
    chk("t4_bmask", mem_bmask, 4'b0011);
    chk("t4_wdata", mem_wdata, 32'h1234_5678);
    chk("t4_addr", mem_addr, 32'h7000);
    tick();                                   // first WAIT cycle, no response
    chk("t4_hold_we", mem_we, 1);
    chk("t4_stall", o_stall_ls, 1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_rvalid = 1'b0; ls_req = 1'b0;
    #1;
    chk("t4_ack", ls_ack, 1);
    tick();

    // ---------------- 5a: flushed fetch ----------------
    if_req = 1'b1; if_addr = 32'h500;
    tick();                                   // REQ
    tick();                                   // WAIT: fetch flushed
    if_req = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    tick();                                   // IDLE again, no ack
    mem_rvalid = 1'b0;
    if_req = 1'b1; if_addr = 32'h504;
    #1;
    chk("t5_flush_noack", if_ack, 0);
    chk("t5_flush_noerr", o_err, 0);

    // ---------------- 5b: timeout ----------------
    tick();                                   // REQ for 0x504
    chk("t5_idle_regrant", mem_req, 1);
    chk("t5_idle_addr", mem_addr, 32'h504);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("t5_wait_noerr", o_err, 0);
      chk("t5_wait_noack", if_ack, 0);
    end
    tick();
    if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;   // late response
    #1;
    chk("t5_to_err", o_err, 1);
    chk("t5_to_ack", if_ack, 1);
    chk("t5_to_rdata", if_rdata, 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("t5_err_pulse", o_err, 0);
    chk("t5_late_noack", if_ack, 0);
    chk("t5_late_noreq", mem_req, 0);

    // ---------------- 5c: response in the timeout cycle ----------------
    ls_req = 1'b1; ls_we = 1'b0; ls_bmask = 4'hF; ls_addr = 32'h6000;
    tick();                                   // REQ
    for (int k = 1; k <= 15; k++) tick();
    tick();                                   // 16th WAIT cycle
    mem_rvalid = 1'b1; mem_rdata = 32'h66;
    tick();
    mem_rvalid = 1'b0; ls_req = 1'b0;
    #1;
    chk("t5c_ack", ls_ack, 1);
    chk("t5c_noerr", o_err, 0);
    chk("t5c_rdata", ls_rdata, 32'h66);
    tick();

    // ---------------- 6: reset mid-WAIT ----------------
    ls_req = 1'b1; ls_we = 1'b1; ls_bmask = 4'hC;
    ls_addr = 32'h8000; ls_wdata = 32'h8888_0000;
    tick();                                   // REQ
    tick();                                   // WAIT
    i_rst_n = 1'b0;
    #1;
    chk("t6_stall_in_rst", o_stall_ls, 1);
    tick();                                   // reset taken
    i_rst_n = 1'b1; ls_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h9999;
    #1;
    chk("t6_ls_ack", ls_ack, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_we", mem_we, 0);
    chk("t6_ls_rdata", ls_rdata, 0);
    chk("t6_stall", o_stall_ls, 0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("t6_late_noack", ls_ack, 0);
    chk("t6_late_noerr", o_err, 0);
    chk("t6_late_noreq", mem_req, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared single-port memory between the instruction-fetch port (IF) and the load/store unit port (LS).
- Sequences each access through request, issue and wait phases, and returns read data with a one-cycle ack.
- Drives stall requests back to the hazard logic so that IF or LS holds while its access is pending.
- Sits between the fetch/LSU stages and the external memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, maximum consecutive LS grants while IF is waiting before IF is forced to win (1..15)
TIMEOUT, 16, maximum WAIT cycles before the access is aborted with an error (2..255)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held high until if_ack or dropped on flush
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch data, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
ls_req  in  1  LSU request; held high until ls_ack
ls_we  in  1  1 = store, 0 = load
ls_bmask  in  4  store byte enables
ls_addr  in  ADDR_W  LSU address
ls_wdata  in  DATA_W  store data
ls_rdata  out  DATA_W  load data, valid when ls_ack=1
ls_ack  out  1  one-cycle completion pulse for LSU
mem_req  out  1  one-cycle issue strobe to memory
mem_we  out  1  write enable
mem_bmask  out  4  byte enables (4'hF for reads)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rvalid  in  1  memory response; also marks write completion
mem_rdata  in  DATA_W  memory read data
o_stall_if  out  1  if_req & ~if_ack (combinational)
o_stall_ls  out  1  ls_req & ~ls_ack (combinational)
o_err  out  1  one-cycle pulse when an access times out

Behaviour:
- States: IDLE, REQ, WAIT. A register `owner` records the granted port (IF or LS).
- IDLE:
  - ls_req=1 and starve_cnt<STARVE_MAX: grant LS.
  - Otherwise if_req=1: grant IF.
  - Otherwise stay in IDLE.
  - On a grant, latch addr/we/bmask/wdata into the mem_* registers and go to REQ next cycle.
  - IF grants force we=0 and bmask=4'hF.
- REQ: mem_req=1 for exactly this cycle, then go to WAIT and clear the timer.
- WAIT:
  - On mem_rvalid=1: capture mem_rdata into the owner's rdata register, pulse the owner's ack next cycle, and return to IDLE.
  - The ack is suppressed if the owner's req is low in the rvalid cycle (flushed fetch); the response is discarded.
  - If the timer reaches TIMEOUT: pulse o_err and the owner's ack (rdata=0), then return to IDLE.
  - A late mem_rvalid arriving afterwards is ignored.
- Latency:
  - Request seen in IDLE at cycle T: mem_req at T+1.
  - Memory responds at R: ack at R+1, state IDLE at R+1.
  - Earliest next grant is evaluated at R+1.
  - Minimum access time is 3 cycles when rvalid arrives in the cycle after REQ.
- Starvation counter starve_cnt:
  - Increments on each LS grant made while if_req=1.
  - Clears on an IF grant or when if_req=0.
  - Saturates at STARVE_MAX.
- mem_rvalid in IDLE or REQ: ignored, no state change.
- mem_addr/mem_wdata/mem_we/mem_bmask hold their values from grant until the next grant.
- Reset (i_rst_n=0 at a clock edge, in any state, including mid-WAIT):
  - State goes to IDLE; starve_cnt and timer go to 0.
  - All outputs go to 0, except o_stall_* which follow their formula.
  - Any outstanding memory response is ignored.
- A simultaneous rvalid and timeout in the same cycle is treated as a normal completion (no o_err).

Test Plan:
1. IF read only: if_req=1, if_addr=0x100, memory returns 0xDEADBEEF one cycle after REQ → mem_req at T+1 with mem_addr=0x100, mem_we=0; if_ack one cycle with if_rdata=0xDEADBEEF at T+3; o_stall_if high T..T+2.
2. Simultaneous requests: if_req and ls_req (load, 0x2000) both high at T → LS is served first; IF mem_req follows after ls_ack; starve_cnt=1 during the LS access.
3. Starvation: ls_req held high for continuous stores, if_req high, STARVE_MAX=4 → four LS grants, then the fifth grant goes to IF.
4. Store: ls_we=1, ls_bmask=4'b0011, ls_wdata=0x1234_5678, addr 0x7000 → mem_we=1, mem_bmask=0011, mem_wdata=0x12345678; ls_ack pulsed after rvalid.
5. Flush and timeout: if_req dropped while in WAIT, then rvalid arrives → no if_ack, state returns to IDLE. In a separate case, no rvalid for 16 WAIT cycles → o_err and ack pulse together, rdata=0.
6. Reset mid-WAIT: assert i_rst_n=0 for one edge → state IDLE and all acks 0; a following rvalid produces no ack.
